// File: rtl/cache_ctrl_seq.sv
// I/D-cache control registers with flush/invalidate sequencing before enable changes commit.
// Sequenced writes stall wvalid for 1 + op-state cycles, then accept in a one-cycle COMMIT.
module cache_ctrl_seq #(
    parameter logic [63:0] ICACHE_ADDR = 64'h0,
    parameter logic [63:0] DCACHE_ADDR = 64'h8,
    parameter int          TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic [63:0] raddr,
    output logic [63:0] rdata,
    output logic        rvalid,
    input  logic        wen,
    input  logic [63:0] waddr,
    input  logic [63:0] wdata,
    input  logic [7:0]  wmask,
    output logic        wvalid,
    output logic        icache_enable,
    output logic        dcache_enable,
    output logic        icache_inv_req,
    input  logic        icache_inv_done,
    output logic        dcache_flush_req,
    input  logic        dcache_flush_done,
    output logic        dcache_inv_req,
    input  logic        dcache_inv_done,
    output logic        busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] D_FLUSH = 3'd1;
    localparam logic [2:0] D_INV   = 3'd2;
    localparam logic [2:0] I_INV   = 3'd3;
    localparam logic [2:0] COMMIT  = 3'd4;

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    logic [2:0]    state, state_nxt, first_st;
    logic          ic_en, ic_err, dc_en, dc_err;
    logic          tgt_d, cap_en, cap_clr;
    logic [CW-1:0] tmo_cnt;
    logic          hit_d, hit_i, eff, start, noop_wr;
    logic          op_st, cur_done, tmo, adv;
    logic          unused_ok;

    assign unused_ok = ^{ren, wdata[63:7], wdata[5:2], wmask[7:1]};

    assign rvalid        = 1'b1;
    assign busy          = (state != IDLE);
    assign icache_enable = ic_en;
    assign dcache_enable = dc_en;

    always_comb begin
        hit_d    = (waddr == DCACHE_ADDR);
        hit_i    = (waddr == ICACHE_ADDR);
        eff      = wen & wmask[0] & (hit_d | hit_i);
        first_st = IDLE;
        // A maintenance trigger on the D-cache always does the full flush+invalidate.
        if (hit_d) begin
            if (wdata[1] || (!wdata[0] && dc_en))
                first_st = D_FLUSH;
            else if (wdata[0] && !dc_en)
                first_st = D_INV;
        end else if (wdata[1] || (wdata[0] != ic_en)) begin
            first_st = I_INV;
        end
        start   = (state == IDLE) && eff && (first_st != IDLE);
        noop_wr = (state == IDLE) && eff && (first_st == IDLE);
        wvalid  = ((state == IDLE) && !start) || (state == COMMIT);
    end

    always_comb begin
        op_st    = (state == D_FLUSH) || (state == D_INV) || (state == I_INV);
        cur_done = ((state == D_FLUSH) && dcache_flush_done) ||
                   ((state == D_INV)   && dcache_inv_done)   ||
                   ((state == I_INV)   && icache_inv_done);
        tmo      = op_st && (tmo_cnt == TMO_LAST);
        adv      = op_st && (cur_done || tmo);
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = first_st;
            D_FLUSH: if (adv) state_nxt = D_INV;
            D_INV:   if (adv) state_nxt = COMMIT;
            I_INV:   if (adv) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata = 64'd0;
        if (raddr == DCACHE_ADDR)
            rdata = {56'd0, busy, dc_err, 5'd0, dc_en};
        else if (raddr == ICACHE_ADDR)
            rdata = {56'd0, busy, ic_err, 5'd0, ic_en};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ic_en            <= 1'b0;
            ic_err           <= 1'b0;
            dc_en            <= 1'b0;
            dc_err           <= 1'b0;
            tgt_d            <= 1'b0;
            cap_en           <= 1'b0;
            cap_clr          <= 1'b0;
            tmo_cnt          <= '0;
            icache_inv_req   <= 1'b0;
            dcache_flush_req <= 1'b0;
            dcache_inv_req   <= 1'b0;
        end else begin
            state            <= state_nxt;
            icache_inv_req   <= (state_nxt == I_INV);
            dcache_flush_req <= (state_nxt == D_FLUSH);
            dcache_inv_req   <= (state_nxt == D_INV);

            if (start) begin
                tgt_d   <= hit_d;
                cap_en  <= wdata[0];
                cap_clr <= wdata[6];
                tmo_cnt <= '0;
            end else if (noop_wr) begin
                if (hit_d) begin
                    dc_en <= wdata[0];
                    if (wdata[6]) dc_err <= 1'b0;
                end else begin
                    ic_en <= wdata[0];
                    if (wdata[6]) ic_err <= 1'b0;
                end
            end else if (op_st) begin
                tmo_cnt <= adv ? '0 : tmo_cnt + 1'b1;
                // Give up on a missing done: flag it and carry on so software is never wedged.
                if (tmo && !cur_done) begin
                    if (tgt_d) dc_err <= 1'b1;
                    else       ic_err <= 1'b1;
                end
            end else if (state == COMMIT) begin
                if (tgt_d) begin
                    dc_en <= cap_en;
                    if (cap_clr) dc_err <= 1'b0;
                end else begin
                    ic_en <= cap_en;
                    if (cap_clr) ic_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_seq.sv
// Directed bench for cache_ctrl_seq: reset, D/I enable sequences, timeout, ignored writes, mid-sequence reset.
module tb_cache_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren;
    logic [63:0] raddr;
    logic [63:0] rdata;
    logic        rvalid;
    logic        wen;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        wvalid;
    logic        icache_enable, dcache_enable;
    logic        icache_inv_req, icache_inv_done;
    logic        dcache_flush_req, dcache_flush_done;
    logic        dcache_inv_req, dcache_inv_done;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cache_ctrl_seq #(
        .ICACHE_ADDR(64'h0),
        .DCACHE_ADDR(64'h8),
        .TIMEOUT    (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ren              (ren),
        .raddr            (raddr),
        .rdata            (rdata),
        .rvalid           (rvalid),
        .wen              (wen),
        .waddr            (waddr),
        .wdata            (wdata),
        .wmask            (wmask),
        .wvalid           (wvalid),
        .icache_enable    (icache_enable),
        .dcache_enable    (dcache_enable),
        .icache_inv_req   (icache_inv_req),
        .icache_inv_done  (icache_inv_done),
        .dcache_flush_req (dcache_flush_req),
        .dcache_flush_done(dcache_flush_done),
        .dcache_inv_req   (dcache_inv_req),
        .dcache_inv_done  (dcache_inv_done),
        .busy             (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ren = 1'b1; raddr = 64'h0; wen = 1'b0; waddr = 64'h0;
        wdata = 64'h0; wmask = 8'h0; icache_inv_done = 1'b0;
        dcache_flush_done = 1'b0; dcache_inv_done = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        n_total++;
        if (rdata !== 64'h0 || rvalid !== 1'b1)
            $display("FAIL reset_read_i: rdata=%h rvalid=%b want 0/1", rdata, rvalid);
        else n_pass++;
        raddr = 64'h8; #1;
        n_total++;
        if (rdata !== 64'h0) $display("FAIL reset_read_d: rdata=%h want 0", rdata);
        else n_pass++;
        n_total++;
        if ({icache_inv_req, dcache_flush_req, dcache_inv_req, icache_enable, dcache_enable, busy, wvalid} !== 7'b0000001)
            $display("FAIL reset_outputs: got %b want 0000001",
                     {icache_inv_req, dcache_flush_req, dcache_inv_req, icache_enable, dcache_enable, busy, wvalid});
        else n_pass++;
    endtask

    task automatic test_dcache_enable();
        step();
        wen = 1'b1; waddr = 64'h8; wdata = 64'h1; wmask = 8'h01; raddr = 64'h8; #1;
        n_total++;
        if (wvalid !== 1'b0 || rdata !== 64'h0) $display("FAIL den_idle: wvalid=%b rdata=%h want 0/0", wvalid, rdata);
        else n_pass++;
        step();
        dcache_inv_done = 1'b1; #1;
        n_total++;
        if ({dcache_inv_req, dcache_flush_req, wvalid, busy} !== 4'b1001 || rdata !== 64'h80)
            $display("FAIL den_inv: req/flush/wvalid/busy=%b rdata=%h want 1001/80",
                     {dcache_inv_req, dcache_flush_req, wvalid, busy}, rdata);
        else n_pass++;
        step();
        dcache_inv_done = 1'b0; #1;
        n_total++;
        if ({dcache_inv_req, wvalid, dcache_enable} !== 3'b010)
            $display("FAIL den_commit: req/wvalid/en=%b want 010", {dcache_inv_req, wvalid, dcache_enable});
        else n_pass++;
        step();
        wen = 1'b0; #1;
        n_total++;
        if (dcache_enable !== 1'b1 || rdata !== 64'h1 || busy !== 1'b0)
            $display("FAIL den_after: en=%b rdata=%h busy=%b want 1/1/0", dcache_enable, rdata, busy);
        else n_pass++;
    endtask

    task automatic test_dcache_disable();
        int lat;
        step();
        wen = 1'b1; waddr = 64'h8; wdata = 64'h0; wmask = 8'h01; raddr = 64'h8; #1;
        lat = 1;
        n_total++;
        if (wvalid !== 1'b0) $display("FAIL ddis_idle: wvalid=%b want 0", wvalid);
        else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            step();
            dcache_inv_done   = (i == 2);
            dcache_flush_done = (i == 4);
            #1;
            lat++;
            n_total++;
            if ({dcache_flush_req, dcache_inv_req, dcache_enable, wvalid} !== 4'b1010)
                $display("FAIL ddis_flush%0d: flush/inv/en/wvalid=%b want 1010", i,
                         {dcache_flush_req, dcache_inv_req, dcache_enable, wvalid});
            else n_pass++;
        end
        for (int i = 1; i <= 2; i++) begin
            step();
            dcache_flush_done = 1'b0;
            dcache_inv_done   = (i == 2);
            #1;
            lat++;
            n_total++;
            if ({dcache_flush_req, dcache_inv_req, dcache_enable, wvalid} !== 4'b0110)
                $display("FAIL ddis_inv%0d: flush/inv/en/wvalid=%b want 0110", i,
                         {dcache_flush_req, dcache_inv_req, dcache_enable, wvalid});
            else n_pass++;
        end
        step();
        dcache_inv_done = 1'b0; #1;
        lat++;
        n_total++;
        if ({dcache_flush_req, dcache_inv_req, dcache_enable, wvalid} !== 4'b0011)
            $display("FAIL ddis_commit: flush/inv/en/wvalid=%b want 0011",
                     {dcache_flush_req, dcache_inv_req, dcache_enable, wvalid});
        else n_pass++;
        n_total++;
        if (lat !== 8) $display("FAIL ddis_latency: got %0d want 8", lat);
        else n_pass++;
        step();
        wen = 1'b0; #1;
        n_total++;
        if (dcache_enable !== 1'b0 || rdata !== 64'h0)
            $display("FAIL ddis_after: en=%b rdata=%h want 0/0", dcache_enable, rdata);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int cnt;
        step();
        wen = 1'b1; waddr = 64'h0; wdata = 64'h2; wmask = 8'h01; raddr = 64'h0; #1;
        n_total++;
        if (wvalid !== 1'b0) $display("FAIL tmo_idle: wvalid=%b want 0", wvalid);
        else n_pass++;
        step();
        cnt = 0;
        while (icache_inv_req === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
        n_total++;
        if (cnt !== 16) $display("FAIL tmo_req_cycles: got %0d want 16", cnt);
        else n_pass++;
        n_total++;
        if (wvalid !== 1'b1 || busy !== 1'b1 || rdata !== 64'hC0)
            $display("FAIL tmo_commit: wvalid=%b busy=%b rdata=%h want 1/1/c0", wvalid, busy, rdata);
        else n_pass++;
        step();
        wen = 1'b0; #1;
        n_total++;
        if (rdata !== 64'h40 || icache_enable !== 1'b0)
            $display("FAIL tmo_err_read: rdata=%h en=%b want 40/0", rdata, icache_enable);
        else n_pass++;
        step();
        wen = 1'b1; wdata = 64'h40; #1;
        n_total++;
        if (wvalid !== 1'b1 || rdata !== 64'h40)
            $display("FAIL tmo_w1c_accept: wvalid=%b rdata=%h want 1/40", wvalid, rdata);
        else n_pass++;
        step();
        wen = 1'b0; #1;
        n_total++;
        if (rdata !== 64'h0 || busy !== 1'b0) $display("FAIL tmo_w1c_read: rdata=%h busy=%b want 0/0", rdata, busy);
        else n_pass++;
    endtask

    task automatic test_ignored_writes();
        step();
        wen = 1'b1; waddr = 64'h10; wdata = 64'h1; wmask = 8'h01; #1;
        n_total++;
        if (wvalid !== 1'b1) $display("FAIL ign_addr_wvalid: wvalid=%b want 1", wvalid);
        else n_pass++;
        step();
        waddr = 64'h8; wdata = 64'h3; wmask = 8'h00; #1;
        n_total++;
        if (wvalid !== 1'b1) $display("FAIL ign_mask_wvalid: wvalid=%b want 1", wvalid);
        else n_pass++;
        step();
        wen = 1'b0; raddr = 64'h8; #1;
        n_total++;
        if ({busy, dcache_enable, icache_enable, dcache_flush_req} !== 4'b0000 || rdata !== 64'h0)
            $display("FAIL ign_state: busy/den/ien/flush=%b rdata=%h want 0000/0",
                     {busy, dcache_enable, icache_enable, dcache_flush_req}, rdata);
        else n_pass++;
        raddr = 64'h10; #1;
        n_total++;
        if (rdata !== 64'h0) $display("FAIL ign_unmapped_read: rdata=%h want 0", rdata);
        else n_pass++;
    endtask

    task automatic test_icache_enable();
        step();
        wen = 1'b1; waddr = 64'h0; wdata = 64'h1; wmask = 8'h01; raddr = 64'h0; #1;
        n_total++;
        if (wvalid !== 1'b0) $display("FAIL ien_idle: wvalid=%b want 0", wvalid);
        else n_pass++;
        step(); #1;
        n_total++;
        if ({icache_inv_req, dcache_inv_req, wvalid} !== 3'b100)
            $display("FAIL ien_inv1: ireq/dreq/wvalid=%b want 100", {icache_inv_req, dcache_inv_req, wvalid});
        else n_pass++;
        step();
        icache_inv_done = 1'b1; dcache_flush_done = 1'b1; #1;
        n_total++;
        if ({icache_inv_req, wvalid} !== 2'b10) $display("FAIL ien_inv2: req/wvalid=%b want 10", {icache_inv_req, wvalid});
        else n_pass++;
        step();
        icache_inv_done = 1'b0; dcache_flush_done = 1'b0; #1;
        n_total++;
        if ({icache_inv_req, wvalid, icache_enable} !== 3'b010)
            $display("FAIL ien_commit: req/wvalid/en=%b want 010", {icache_inv_req, wvalid, icache_enable});
        else n_pass++;
        step();
        wen = 1'b0; #1;
        n_total++;
        if (icache_enable !== 1'b1 || dcache_enable !== 1'b0 || rdata !== 64'h1)
            $display("FAIL ien_after: ien=%b den=%b rdata=%h want 1/0/1", icache_enable, dcache_enable, rdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid_seq();
        step();
        wen = 1'b1; waddr = 64'h8; wdata = 64'h1; wmask = 8'h01; raddr = 64'h8; #1;
        step();
        dcache_inv_done = 1'b1; #1;
        step();
        dcache_inv_done = 1'b0; #1;
        step();
        wen = 1'b0; #1;
        n_total++;
        if (dcache_enable !== 1'b1) $display("FAIL rst_setup_en: en=%b want 1", dcache_enable);
        else n_pass++;
        step();
        wen = 1'b1; wdata = 64'h0; #1;
        step(); #1;
        n_total++;
        if (dcache_flush_req !== 1'b1) $display("FAIL rst_flush_req: got %b want 1", dcache_flush_req);
        else n_pass++;
        step();
        rst = 1'b1; dcache_flush_done = 1'b1; #1;
        step();
        rst = 1'b0; dcache_flush_done = 1'b0; wen = 1'b0; #1;
        n_total++;
        if ({dcache_flush_req, dcache_inv_req, busy, dcache_enable, icache_enable} !== 5'b00000)
            $display("FAIL rst_after: flush/inv/busy/den/ien=%b want 00000",
                     {dcache_flush_req, dcache_inv_req, busy, dcache_enable, icache_enable});
        else n_pass++;
        step();
        dcache_flush_done = 1'b1; #1;
        step();
        dcache_flush_done = 1'b0; #1;
        n_total++;
        if ({dcache_flush_req, dcache_inv_req, busy, dcache_enable} !== 4'b0000 || rdata !== 64'h0)
            $display("FAIL rst_late_done: flush/inv/busy/en=%b rdata=%h want 0000/0",
                     {dcache_flush_req, dcache_inv_req, busy, dcache_enable}, rdata);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dcache_enable();
        test_dcache_disable();
        test_timeout();
        test_ignored_writes();
        test_icache_enable();
        test_reset_mid_seq();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_seq.md
# cache_ctrl_seq

Cache-control sequencer on the memory-mapped configuration path. It owns the I-cache and D-cache control registers, and it sequences the flush and invalidate handshakes with both caches whenever software changes an enable bit or requests a maintenance operation. Enable outputs change only after the required cache operations have completed. Configuration writes are stalled through `wvalid` while a sequence is in flight.

## Interface

Parameters:

- `ICACHE_ADDR`, default 64'h0, byte address of the I-cache control register.
- `DCACHE_ADDR`, default 64'h8, byte address of the D-cache control register.
- `TIMEOUT`, default 1024, maximum cycles to wait for any done pulse. Must be at least 2.

Ports:

- `clk` input 1: clock. One clock domain only; every register updates on rising `clk`.
- `rst` input 1: reset. Synchronous and active-high.
- `ren` input 1: read request.
- `raddr` input 64: read address.
- `rdata` output 64: read data, combinational.
- `rvalid` output 1: constant 1.
- `wen` input 1: write request.
- `waddr` input 64: write address.
- `wdata` input 64: write data.
- `wmask` input 8: byte mask. Only `wmask[0]` is used.
- `wvalid` output 1: write accepted. The master holds `wen`, `waddr`, `wdata` and `wmask` stable until it samples `wvalid`=1.
- `icache_enable` output 1: committed I-cache enable.
- `dcache_enable` output 1: committed D-cache enable.
- `icache_inv_req` output 1: I-cache invalidate request, level.
- `icache_inv_done` input 1: I-cache invalidate complete, 1-cycle pulse.
- `dcache_flush_req` output 1: D-cache write-back-all request, level.
- `dcache_flush_done` input 1: D-cache flush complete, pulse.
- `dcache_inv_req` output 1: D-cache invalidate request, level.
- `dcache_inv_done` input 1: D-cache invalidate complete, pulse.
- `busy` output 1: high when the state is not IDLE.

## Operation

Register layout, identical at both addresses:

- bit0: enable.
- bit1: maintenance trigger. Write-only; reads as 0.
- bit6: error, sticky. Write 1 to clear.
- bit7: `busy`.
- All other bits read 0.

Read path:

- `rdata` shows the matching register for `raddr`; any other address reads 0.
- Reads are allowed in every state.

Write decode, evaluated in IDLE only. A write is effective when `wen`=1, `wmask[0]`=1 and `waddr` matches one of the two register addresses. Any other write gets `wvalid`=1 in the same cycle and has no effect.

Required operation sequence per effective write:

- D-cache write, new enable = 0 while current = 1: D_FLUSH, then D_INV, then COMMIT.
- D-cache write, new enable = 1 while current = 0: D_INV, then COMMIT.
- D-cache write with bit1 = 1: D_FLUSH, then D_INV, then COMMIT. This takes priority over the two rules above and covers them.
- I-cache write where the enable bit changes, or bit1 = 1: I_INV, then COMMIT.
- No operation needed: `wvalid`=1 in the same cycle, and the register updates at the next edge.

FSM states: IDLE, D_FLUSH, D_INV, I_INV, COMMIT.

- IDLE, effective write needing an operation: `wvalid`=0. Capture the target, the new enable value and the W1C bit. Go to the first operation state.
- Operation state: the matching req is high for every cycle spent in the state. On a done pulse, go to the next state, and the req drops at that same edge. Done inputs are ignored in every other state, and a done that does not match the current state is ignored.
- Timeout counter: cleared on entry to each operation state. If it reaches `TIMEOUT`-1 with no done, set the target register's error bit and advance as if done had arrived.
- COMMIT, one cycle: `wvalid`=1. The captured enable is written, and the error bit is cleared if the captured bit6 was 1. Return to IDLE.
- `busy` = (state != IDLE).

Reset values:

- All outputs 0 except `rvalid`=1.
- `wvalid` follows the combinational IDLE decode above.
- Both registers 0, state IDLE, timeout counter 0.

## Timing

- Registered reqs: a req is high from the first cycle in its state through the cycle in which done is sampled.
- A done pulse arriving in the first cycle of a state is accepted. That state then lasts exactly 1 cycle.
- Enable outputs change at the edge that ends COMMIT. They are visible in the cycle after `wvalid`=1.
- Latency for a sequenced write = 1 (IDLE) + sum of the per-state cycles + 1 (COMMIT).
- Reset asserted mid-sequence:
  - At the next edge all reqs drop, both enables go to 0, the state becomes IDLE and the in-flight write is discarded.
  - Done pulses arriving during reset are ignored.
- Reads in the same cycle as a write return the pre-write value.

## Test plan

- Reset, then read both addresses: `rdata`=0 and `rvalid`=1. All reqs, enables and `busy` are 0.
- Write `DCACHE_ADDR` with 0x1 and `wmask` 0x01, with `dcache_inv_done` pulsed in the first D_INV cycle:
  - `dcache_inv_req` is high for 1 cycle.
  - `wvalid` is low for 2 cycles, then high in COMMIT.
  - `dcache_enable`=1 in the following cycle. A readback gives 0x1.
- With the D-cache enabled, write `DCACHE_ADDR` with 0x0, and pulse flush_done 3 cycles after req rises and inv_done 1 cycle after:
  - Order is flush, then invalidate.
  - `dcache_enable` stays 1 until the cycle after COMMIT.
  - Total latency 8 cycles.
- Write `ICACHE_ADDR` with 0x2 and never drive done, with `TIMEOUT`=16:
  - `icache_inv_req` is high for 16 cycles.
  - Then COMMIT, after which a read gives 0x40 (error set, enable 0).
  - A following write of 0x40 reads back 0x0.
- Write to another address, and write with `wmask`=0x00: `wvalid`=1 in the same cycle and both registers are unchanged.
- Assert `rst` for 1 cycle during D_FLUSH:
  - Next cycle `dcache_flush_req`=0, `busy`=0, enables 0.
  - A late flush_done has no effect.
